// File: rtl/out_port_arbiter_pkg.sv
// Shared definitions for the 7-segment output arbiter: source ids,
// default display width and the arbiter state encoding.
package out_pkg;

    localparam int OUT_WIDTH = 28;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/out_port_arbiter_hold_timer.sv
// Loadable down-counter that measures how long a displayed value is held.
// Load sets HOLD_CYCLES-1; the count stops at zero and done flags zero.
module hold_timer #(
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clr,
    output logic done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CW'(HOLD_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter between the cpu OUT path and the debug source that
// latches the winning value for the display and holds it HOLD_CYCLES cycles.
module out_port_arbiter
    import out_pkg::*;
#(
    parameter int WIDTH       = OUT_WIDTH,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_valid,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             cpu_ready,
    input  logic             dbg_valid,
    input  logic [WIDTH-1:0] dbg_data,
    output logic             dbg_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             outp_3,
    output logic             busy,
    output logic             last_src
);

    // Handshake: a write transfers on the rising edge where valid && ready;
    // the requester keeps valid/data stable until then or withdraws valid.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             outp3_q, outp3_d;
    logic             last_src_q, last_src_d;
    logic             rr_q, rr_d;
    logic             grant_cpu, grant_dbg;
    logic             accept;
    logic             timer_load, timer_clr, timer_done;

    // rr_q remembers the last winner; the other source wins a tie.
    assign grant_cpu = cpu_valid && (!dbg_valid || rr_q == SRC_DBG);
    assign grant_dbg = dbg_valid && (!cpu_valid || rr_q == SRC_CPU);

    assign cpu_ready = (state_q == ST_IDLE) && !clear && grant_cpu;
    assign dbg_ready = (state_q == ST_IDLE) && !clear && grant_dbg;
    assign accept    = cpu_ready || dbg_ready;

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        outp3_d    = outp3_q;
        last_src_d = last_src_q;
        rr_d       = rr_q;
        timer_load = 1'b0;
        timer_clr  = 1'b0;
        if (clear) begin
            state_d   = ST_IDLE;
            out_d     = '0;
            outp3_d   = 1'b0;
            timer_clr = 1'b1;
        end else if (accept) begin
            state_d    = ST_HOLD;
            out_d      = cpu_ready ? cpu_data : dbg_data;
            outp3_d    = 1'b1;
            last_src_d = cpu_ready ? SRC_CPU : SRC_DBG;
            rr_d       = cpu_ready ? SRC_CPU : SRC_DBG;
            timer_load = 1'b1;
        end else if (state_q == ST_HOLD && timer_done) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            outp3_q    <= 1'b0;
            last_src_q <= SRC_CPU;
            rr_q       <= SRC_DBG;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            outp3_q    <= outp3_d;
            last_src_q <= last_src_d;
            rr_q       <= rr_d;
        end
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .clr  (timer_clr),
        .done (timer_done)
    );

    assign out      = out_q;
    assign outp_3   = outp3_q;
    assign busy     = (state_q == ST_HOLD);
    assign last_src = last_src_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed and randomized bench for out_port_arbiter with a cycle-numbered
// reference model of acceptance, hold windows and display contents.
module tb_out_port_arbiter;

    localparam int W = 28;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_valid;
    logic [W-1:0] cpu_data;
    logic         cpu_ready;
    logic         dbg_valid;
    logic [W-1:0] dbg_data;
    logic         dbg_ready;
    logic         clear;
    logic [W-1:0] out;
    logic         outp_3;
    logic         busy;
    logic         last_src;

    out_port_arbiter #(
        .WIDTH(W),
        .HOLD_CYCLES(H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_valid(cpu_valid),
        .cpu_data (cpu_data),
        .cpu_ready(cpu_ready),
        .dbg_valid(dbg_valid),
        .dbg_data (dbg_data),
        .dbg_ready(dbg_ready),
        .clear    (clear),
        .out      (out),
        .outp_3   (outp_3),
        .busy     (busy),
        .last_src (last_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: the display contents plus the first cycle number at which a
    // new write may be accepted again.
    logic [W-1:0] m_out;
    logic         m_en;
    logic         m_last;
    logic         m_rr;
    int           idle_from;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic idle, g_cpu, g_dbg, a_cpu, a_dbg;
        @(negedge clk);
        idle  = (cyc >= idle_from);
        g_cpu = cpu_valid && (!dbg_valid || m_rr == 1'b1);
        g_dbg = dbg_valid && (!cpu_valid || m_rr == 1'b0);
        a_cpu = idle && !clear && g_cpu;
        a_dbg = idle && !clear && g_dbg;
        chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, a_cpu});
        chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, a_dbg});
        chk("one_ready", {31'd0, cpu_ready & dbg_ready}, 32'd0);
        chk("out", {4'd0, out}, {4'd0, m_out});
        chk("outp_3", {31'd0, outp_3}, {31'd0, m_en});
        chk("busy", {31'd0, busy}, {31'd0, !idle});
        chk("last_src", {31'd0, last_src}, {31'd0, m_last});
        if (reset) begin
            m_out = '0; m_en = 1'b0; m_last = 1'b0; m_rr = 1'b1;
            idle_from = cyc + 1;
        end else if (clear) begin
            m_out = '0; m_en = 1'b0;
            idle_from = cyc + 1;
        end else if (a_cpu) begin
            m_out = cpu_data; m_en = 1'b1; m_last = 1'b0; m_rr = 1'b0;
            idle_from = cyc + 1 + H;
        end else if (a_dbg) begin
            m_out = dbg_data; m_en = 1'b1; m_last = 1'b1; m_rr = 1'b1;
            idle_from = cyc + 1 + H;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (!reset && a_cpu) cpu_valid = 1'b0;
        if (!reset && a_dbg) dbg_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req_cpu(input logic [W-1:0] d);
        cpu_valid = 1'b1;
        cpu_data  = d;
    endtask

    task automatic req_dbg(input logic [W-1:0] d);
        dbg_valid = 1'b1;
        dbg_data  = d;
    endtask

    function automatic logic [W-1:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return 28'h8000000;
            1:       return 28'hFFFFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; clear = 1'b0;
        cpu_valid = 1'b0; cpu_data = '0;
        dbg_valid = 1'b0; dbg_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_out = '0; m_en = 1'b0; m_last = 1'b0; m_rr = 1'b1; idle_from = 0;

        // Idle after reset.
        run(3);

        // Single cpu write held for H cycles.
        req_cpu(28'h0000123);
        step();
        chk("plan_cpu_out", {4'd0, out}, 32'h0000123);
        chk("plan_cpu_busy", {31'd0, busy}, 32'd1);
        run(H + 2);

        // Both sources requesting continuously: alternate winners.
        for (int k = 0; k < 4 * (H + 1); k++) begin
            if (!cpu_valid) req_cpu(28'h0000001);
            if (!dbg_valid) req_dbg(28'hFFFFFFF);
            step();
        end
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        run(H + 1);

        // cpu request arriving during a debug hold waits for IDLE.
        req_dbg(28'h00ABCDE);
        run(2);
        req_cpu(28'h0000456);
        run(H + 2);
        chk("plan_wait_out", {4'd0, out}, 32'h0000456);
        run(H);

        // clear during HOLD with cpu pending; cpu accepted on the next cycle.
        req_dbg(28'h0055555);
        step();
        req_cpu(28'h0000777);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("plan_clear_out", {4'd0, out}, 32'd0);
        step();
        chk("plan_clear_accept", {4'd0, out}, 32'h0000777);
        run(H + 1);

        // reset mid-HOLD, then a tie goes to cpu.
        req_dbg(28'h8000000);
        run(2);
        chk("plan_neg_out", {4'd0, out}, 32'h8000000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("plan_reset_out", {4'd0, out}, 32'd0);
        req_cpu(28'h0000321);
        req_dbg(28'h0000654);
        step();
        chk("plan_tie_src", {31'd0, last_src}, 32'd0);
        run(H + 3);

        // Randomized traffic with withdrawals, clears and occasional resets.
        for (int k = 0; k < 600; k++) begin
            if (!cpu_valid && $urandom_range(0, 3) == 0) req_cpu(pick_data());
            else if (cpu_valid && $urandom_range(0, 15) == 0) cpu_valid = 1'b0;
            if (!dbg_valid && $urandom_range(0, 3) == 0) req_dbg(pick_data());
            else if (dbg_valid && $urandom_range(0, 15) == 0) dbg_valid = 1'b0;
            clear = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        clear = 1'b0; reset = 1'b0;
        run(H + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
- Sequences writes to the 7-segment output device (28-bit signed value plus display-enable select bit).
- Arbitrates between two requesters, the processor OUT path (cpu) and a debug source (dbg), using valid/ready handshakes.
- Latches the accepted value and holds it for a programmable minimum time so every displayed value stays readable.
- Sits between the core/debug logic and the output device's out / outp_3 inputs.

Parameters:
- WIDTH, 28, data width of displayed value (two's complement, sign bit WIDTH-1).
- HOLD_CYCLES, 1000000, minimum cycles a value stays displayed before the next write is accepted; must be ≥1.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- cpu_valid  input  1  cpu write request
- cpu_data  input  WIDTH  cpu write value
- cpu_ready  output  1  cpu write accepted this cycle when high with cpu_valid
- dbg_valid  input  1  debug write request
- dbg_data  input  WIDTH  debug write value
- dbg_ready  output  1  debug write accepted this cycle when high with dbg_valid
- clear  input  1  synchronous display clear
- out  output  WIDTH  registered display value to output device
- outp_3  output  1  display-enable select bit to output device
- busy  output  1  high while in HOLD
- last_src  output  1  source of current display value (0 = cpu, 1 = dbg)

Behaviour:
- Reset (synchronous, active-high) is checked first every edge:
  - out=0, outp_3=0, busy=0, last_src=0.
  - State=IDLE, hold counter=0, round-robin pointer = "dbg won last", so cpu wins the first tie.
  - Reset mid-HOLD aborts the hold immediately.
- States:
  - IDLE: may accept a write.
  - HOLD: counting; no acceptance.
- Grant, combinational, IDLE only:
  - Only one valid asserted: that source is granted.
  - Both valid: the source not granted last is granted.
  - cpu_ready = IDLE && !clear && grant_cpu; dbg_ready likewise. At most one ready high per cycle.
  - Ready may depend on valid.
- Requester rules: valid and data must stay stable until accepted. Deasserting valid without acceptance is legal (request withdrawn); the block keeps no memory of it.
- Accept edge (valid && ready):
  - out <= granted data, unmodified. No sign conversion here; the output device handles sign display.
  - outp_3 <= 1, last_src <= granted id, rr pointer <= granted id.
  - counter <= HOLD_CYCLES-1, state <= HOLD.
- HOLD:
  - Both readys 0.
  - counter==0 → IDLE; otherwise counter decrements.
  - HOLD lasts exactly HOLD_CYCLES cycles. Minimum accept-to-accept interval is HOLD_CYCLES+1 cycles.
- Latency: value appears on out the cycle after acceptance. busy=1 from that cycle for HOLD_CYCLES cycles.
- clear, any state:
  - out <= 0, outp_3 <= 0, state <= IDLE, counter <= 0.
  - rr pointer and last_src are unchanged.
  - Overrides a same-cycle acceptance: readys are forced 0, so nothing is accepted.
  - reset overrides clear.
- Counter width: $clog2(HOLD_CYCLES+1). No wrap; the counter never decrements below 0.
- Boundary values pass through unmodified, including 28'h8000000 (most negative) and 28'hFFFFFFF (-1).
- out holds its value indefinitely in IDLE; only an accept, clear or reset changes it.

Decomposition:
- Shared package out_pkg:
  - OUT_WIDTH=28.
  - Source ids SRC_CPU=1'b0, SRC_DBG=1'b1.
  - State enum {ST_IDLE, ST_HOLD}.
- One natural sub-module: hold_timer, a loadable down-counter.
  - Inputs: load, clr.
  - Output: done, asserted when count==0 in HOLD.
  - The arbiter top owns the grant logic and the output registers.

Test Plan:
- Reset, then no requests → out=0, outp_3=0, busy=0, cpu_ready=dbg_ready=0.
- HOLD_CYCLES=4; cpu_valid=1 with cpu_data=28'h0000123 at cycle 0:
  - cpu_ready=1 at cycle 0.
  - out=28'h0000123, outp_3=1, last_src=0 from cycle 1.
  - busy=1 during cycles 1–4, 0 at cycle 5.
- Both valid held continuously (cpu=28'h1, dbg=28'hFFFFFFF), HOLD_CYCLES=4 → accepts at cycles 0,5,10,15 alternate cpu,dbg,cpu,dbg; out alternates 1, FFFFFFF; never both readys high.
- dbg write at cycle 0, cpu_valid raised at cycle 2 (during HOLD) → cpu_ready=0 through cycle 4; accepted at cycle 5; out=cpu_data from cycle 6.
- clear at cycle 2 of HOLD with cpu_valid pending → cycle 3: out=0, outp_3=0, busy=0; cpu accepted at cycle 3 (not cycle 2).
- reset mid-HOLD with new value 28'h8000000 displayed → next cycle all outputs 0 and state IDLE; first post-reset tie grants cpu.
